jtag_reg_master: RTL and testbench
==================================

JTAG_REG_MASTER -- requirements
Module: jtag_reg_master

Interface
REQ-001 SHALL have parameter TCK_HALF, default 2, meaning clk_sys cycles per TCK half-period (legal ≥1).
REQ-002 SHALL have parameter GAP_TCKS, default 4, meaning idle TCK cycles after each UPDATE-DR (legal ≥2, covers toggle CDC in the register bridge).
REQ-003 SHALL have parameter DRW, default 40, meaning DR length: [39:8]=data, [7:0]=addr.
REQ-004 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_sys  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both high.
REQ-007 cmd_write  in  1  1=WRITE_REG, 0=READ_REG.
REQ-008 cmd_addr / cmd_wdata  in  8 / 32  register address / write data.
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-010 rsp_rdata / rsp_err  out  32 / 1  read data (0 for writes) / address-echo mismatch.
REQ-011 tck, tdi  out  1, 1  generated JTAG clock and serial data to the bridge.
REQ-012 ir_out  out  2  instruction: 2'b01 write, 2'b10 read, 2'b00 idle.
REQ-013 vs_cdr, vs_sdr, vs_udr  out  1 each  CAPTURE-DR / SHIFT-DR / UPDATE-DR strobes.
REQ-014 tdo  in  1  serial data from the bridge.

Function
REQ-015 SHALL have states IDLE, CDR, SHIFT, UDR, GAP, RESP; tck held 0 in IDLE and RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; on accept, latch cmd_*, drive ir_out, and enter CDR.
REQ-017 One TCK cycle = TCK_HALF low clk_sys cycles then TCK_HALF high; tdi, ir_out and vs_* change only on the clk_sys edge where tck goes 1→0, or on accept.
REQ-018 CDR: 1 TCK cycle with vs_cdr=1. SHIFT: exactly DRW TCK cycles with vs_sdr=1. UDR: 1 TCK cycle with vs_udr=1. GAP: GAP_TCKS cycles with all vs_*=0.
REQ-019 Shift word SHALL be {cmd_wdata, cmd_addr} for writes and {32'h0, cmd_addr} for reads; bit i is driven on tdi during SHIFT cycle i, LSB first.
REQ-020 During SHIFT, tdo SHALL be sampled on the clk_sys edge where tck goes 0→1; sample i is stored into capture bit i.
REQ-021 Write: one scan (CDR-SHIFT-UDR-GAP), then RESP with rsp_rdata=0 and rsp_err=0.
REQ-022 Read: scan 1 (address latch), then scan 2 with the identical shift word, then RESP with rsp_rdata=capture[39:8] and rsp_err=(capture[7:0]!=cmd_addr).
REQ-023 Scan-1 capture SHALL be discarded.
REQ-024 In RESP, rsp_valid=1 with data stable until rsp_ready; on handshake go to IDLE, ir_out=00.
REQ-025 Write latency, accept edge to rsp_valid=1: (DRW+2+GAP_TCKS)*2*TCK_HALF clk_sys cycles.
REQ-026 Read latency: twice the write latency.
REQ-027 A bit counter SHALL count 0..DRW-1 and stop; no wrap. cmd_valid outside IDLE SHALL be ignored.
REQ-028 rsp_ready=1 in the same cycle rsp_valid rises SHALL complete the handshake on that edge.

Reset
REQ-029 rst_sys, including mid-scan, SHALL asynchronously force IDLE, tck=0, tdi=0, ir_out=00, vs_*=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0 while asserted, and clear all counters.
REQ-030 cmd_ready SHALL be 1 on the first clk_sys edge after reset release.

Verification
REQ-031 Write 0x01←0x00000080 into a bridge model with defaults -> 40 tdi bits equal 0x0000008001 LSB-first; bridge reg_in_w=128; rsp_valid after 184 cycles, rsp_rdata=0.
REQ-032 Read 0x10 with bridge status done=1 -> rsp_rdata=0x00000001, rsp_err=0, latency 368 cycles.
REQ-033 Read unmapped 0x55 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-034 tdo stuck at 0 on read of 0x02 -> rsp_rdata=0, rsp_err=1.
REQ-035 Assert rst_sys at SHIFT bit 20 -> tck, vs_*, ir_out become 0 immediately; a subsequent write 0x03←0xCD completes normally.
REQ-036 With TCK_HALF=1, hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stay stable, cmd_ready=0 throughout, IDLE after handshake.

Source files
------------

// File: rtl/jtag_reg_master.sv
// rtl/jtag_reg_master.sv - register read/write master driving a JTAG DR-scan register bridge
`timescale 1ns/1ps
module jtag_reg_master #(
   parameter int TCK_HALF = 2,
   parameter int GAP_TCKS = 4,
   parameter int DRW      = 40
) (
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        tck,
   output logic        tdi,
   output logic [1:0]  ir_out,
   output logic        vs_cdr,
   output logic        vs_sdr,
   output logic        vs_udr,
   input  logic        tdo
);
   localparam int HW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
   localparam int BW = (DRW > 1) ? $clog2(DRW) : 1;
   localparam int GW = (GAP_TCKS > 1) ? $clog2(GAP_TCKS) : 1;
   localparam logic [HW-1:0] H_LAST = HW'(TCK_HALF - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DRW - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_TCKS - 1);

   typedef enum logic [2:0] {IDLE, CDR, SHIFT, UDR, GAP, RESP} state_t;
   state_t state, state_d;

   logic [HW-1:0]  hcnt;
   logic [BW-1:0]  bit_cnt;
   logic [GW-1:0]  gap_cnt;
   logic [DRW-1:0] word;
   logic [DRW-1:0] cap;
   logic [7:0]     addr_q;
   logic           wr_q;
   logic           second;
   logic           scanning;
   logic           tck_rise;
   logic           tck_fall;
   logic           accept;
   logic           scan_done;

   assign scanning  = (state == CDR) || (state == SHIFT) || (state == UDR) || (state == GAP);
   assign tck_rise  = scanning && !tck && (hcnt == H_LAST);
   assign tck_fall  = scanning && tck && (hcnt == H_LAST);
   assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
   assign scan_done = (state == GAP) && tck_fall && (gap_cnt == G_LAST);

   // Strobes decode straight from state, so reset clears them without waiting for a clock
   assign vs_cdr    = (state == CDR);
   assign vs_sdr    = (state == SHIFT);
   assign vs_udr    = (state == UDR);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) state <= IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = CDR;
         CDR:     if (tck_fall) state_d = SHIFT;
         SHIFT:   if (tck_fall && (bit_cnt == B_LAST)) state_d = UDR;
         UDR:     if (tck_fall) state_d = GAP;
         GAP:     if (scan_done) state_d = (!wr_q && !second) ? CDR : RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         cmd_ready <= 1'b0;
         tck       <= 1'b0;
         tdi       <= 1'b0;
         ir_out    <= 2'b00;
         hcnt      <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         word      <= '0;
         cap       <= '0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         second    <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         cmd_ready <= (state_d == IDLE);

         if (scanning) begin
            if (hcnt == H_LAST) begin
               hcnt <= '0;
               tck  <= ~tck;
            end else begin
               hcnt <= hcnt + 1'b1;
            end
         end else begin
            hcnt <= '0;
            tck  <= 1'b0;
         end

         if (accept) begin
            wr_q    <= cmd_write;
            addr_q  <= cmd_addr;
            word    <= cmd_write ? DRW'({cmd_wdata, cmd_addr}) : DRW'({32'h0, cmd_addr});
            ir_out  <= cmd_write ? 2'b01 : 2'b10;
            second  <= 1'b0;
            tdi     <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
         end

         // Bit 0 goes out on the falling edge that opens SHIFT; the rest follow one per TCK
         if ((state == CDR) && tck_fall) begin
            tdi     <= word[0];
            bit_cnt <= '0;
         end
         if ((state == SHIFT) && tck_rise) cap <= {tdo, cap[DRW-1:1]};
         if ((state == SHIFT) && tck_fall) begin
            if (bit_cnt == B_LAST) begin
               tdi <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               tdi     <= word[bit_cnt + 1'b1];
            end
         end

         if ((state == UDR) && tck_fall) gap_cnt <= '0;
         if ((state == GAP) && tck_fall && !scan_done) gap_cnt <= gap_cnt + 1'b1;

         // A read's first scan only latches the address; its capture is overwritten by scan 2
         if (scan_done) begin
            if (!wr_q && !second) begin
               second <= 1'b1;
            end else begin
               rsp_rdata <= wr_q ? 32'h0 : cap[8 +: 32];
               rsp_err   <= !wr_q && (cap[7:0] != addr_q);
            end
         end

         if ((state == RESP) && rsp_ready) ir_out <= 2'b00;
      end
   end
endmodule

// File: tb/tb_jtag_reg_master.sv
// tb/tb_jtag_reg_master.sv - self-checking bench for jtag_reg_master with a DR-scan bridge model
`timescale 1ns/1ps
module tb_jtag_reg_master;
   localparam int TH  = 2;
   localparam int GAP = 4;
   localparam int DRW = 40;
   localparam int LW  = (DRW + 2 + GAP) * 2 * TH;

   logic        clk_sys = 1'b0;
   logic        rst_sys = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = 8'h0;
   logic [31:0] cmd_wdata = 32'h0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;
   logic        tck, tdi, tdo, vs_cdr, vs_sdr, vs_udr;
   logic [1:0]  ir_out;

   logic        f_cmd_valid = 1'b0, f_cmd_ready, f_rsp_valid, f_rsp_ready = 1'b0, f_rsp_err;
   logic [31:0] f_rsp_rdata;
   logic        f_tck, f_tdi, f_vs_cdr, f_vs_sdr, f_vs_udr;
   logic [1:0]  f_ir_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc++;

   jtag_reg_master #(.TCK_HALF(TH), .GAP_TCKS(GAP), .DRW(DRW)) u_dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .tck(tck), .tdi(tdi), .ir_out(ir_out),
      .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdo(tdo));

   jtag_reg_master #(.TCK_HALF(1), .GAP_TCKS(GAP), .DRW(DRW)) u_fast (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_write(1'b0),
      .cmd_addr(8'h05), .cmd_wdata(32'h0),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err),
      .tck(f_tck), .tdi(f_tdi), .ir_out(f_ir_out),
      .vs_cdr(f_vs_cdr), .vs_sdr(f_vs_sdr), .vs_udr(f_vs_udr), .tdo(1'b1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Register bridge: 0x00-0x0F read/write, 0x10 status (done=1), anything else reads 0xDEADBEEF
   logic [31:0] br_mem [16];
   logic [7:0]  br_addr = 8'h0;
   logic [39:0] dr = '0;
   logic [39:0] last_word = '0;
   logic        tdo_drv = 1'b0;
   logic        stuck0 = 1'b0;
   int          sbits = 0;
   logic [39:0] m_word = '0;

   function automatic logic [31:0] br_read(input logic [7:0] a);
      if (a < 8'h10)       return br_mem[a[3:0]];
      else if (a == 8'h10) return 32'h1;
      else                 return 32'hDEADBEEF;
   endfunction

   assign tdo = stuck0 ? 1'b0 : tdo_drv;

   always @(posedge tck) begin
      if (vs_cdr) begin
         dr = (ir_out == 2'b10) ? {br_read(br_addr), br_addr} : 40'h0;
         sbits = 0;
      end else if (vs_sdr) begin
         dr = {tdi, dr[39:1]};
         sbits++;
      end else if (vs_udr) begin
         last_word = dr;
         chk("tdi_word", dr, m_word);
         chk("shift_count", sbits, DRW);
         if (ir_out == 2'b01) begin
            if (dr[7:0] < 8'h10) br_mem[dr[3:0]] = dr[39:8];
         end else if (ir_out == 2'b10) begin
            br_addr = dr[7:0];
         end
      end
   end
   always @(negedge tck) tdo_drv = dr[0];

   // Transaction-level reference: phase 0 idle, 1 scanning (fixed latency), 2 responding
   logic [31:0] m_mem [16];
   int          m_phase = 0;
   int          m_cnt = 0;
   bit          m_ready = 1'b0;
   bit          m_write = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        m_err = 1'b0;

   function automatic logic [31:0] exp_read(input logic [7:0] a);
      if (a < 8'h10)       return m_mem[a[3:0]];
      else if (a == 8'h10) return 32'h1;
      else                 return 32'hDEADBEEF;
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) begin
         br_mem[i] = 32'h0;
         m_mem[i]  = 32'h0;
      end
   end

   always @(posedge clk_sys) begin
      if (rst_sys) begin
         m_phase = 0;
         m_ready = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               if (m_ready && cmd_valid) begin
                  m_write = cmd_write;
                  m_word  = cmd_write ? {cmd_wdata, cmd_addr} : {32'h0, cmd_addr};
                  m_cnt   = cmd_write ? LW : 2 * LW;
                  if (cmd_write) begin
                     if (cmd_addr < 8'h10) m_mem[cmd_addr[3:0]] = cmd_wdata;
                     m_rdata = 32'h0;
                     m_err   = 1'b0;
                  end else if (stuck0) begin
                     m_rdata = 32'h0;
                     m_err   = (cmd_addr != 8'h0);
                  end else begin
                     m_rdata = exp_read(cmd_addr);
                     m_err   = 1'b0;
                  end
                  m_phase = 1;
                  m_ready = 1'b0;
               end else begin
                  m_ready = 1'b1;
               end
            end
            1: begin
               m_cnt--;
               if (m_cnt == 0) m_phase = 2;
            end
            default: begin
               if (rsp_ready) begin
                  m_phase = 0;
                  m_ready = 1'b1;
               end
            end
         endcase
      end
   end

   always @(negedge clk_sys) begin
      if (!rst_sys) begin
         chk("cmd_ready", cmd_ready, (m_phase == 0) && m_ready);
         chk("rsp_valid", rsp_valid, m_phase == 2);
         if (m_phase == 2) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
         end
         chk("ir_out", ir_out, (m_phase == 0) ? 2'b00 : (m_write ? 2'b01 : 2'b10));
         if (m_phase != 1) chk("jtag_quiet", {tck, vs_cdr, vs_sdr, vs_udr}, 4'b0);
      end
   end

   task automatic do_cmd(input bit w, input logic [7:0] a, input logic [31:0] d, input int hold,
                         input bit early, output logic [31:0] rd, output logic e, output int lat);
      int n;
      int t0;
      n = 0;
      @(negedge clk_sys);
      while (!cmd_ready && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      @(negedge clk_sys);
      t0        = cyc;
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = $urandom;
      rsp_ready = early;
      n = 0;
      while (!rsp_valid && n < 2000) begin
         @(negedge clk_sys);
         n++;
      end
      lat = cyc - t0;
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
      rd = rsp_rdata;
      e  = rsp_err;
      if (!early) begin
         repeat (hold) @(negedge clk_sys);
         rsp_ready = 1'b1;
      end
      @(negedge clk_sys);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat;
      int          n;
      int          t0;
      bit          w;
      logic [7:0]  a;

      repeat (3) @(negedge clk_sys);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_outputs", {rsp_valid, tck, tdi, ir_out, vs_cdr, vs_sdr, vs_udr}, 0);
      chk("rst_rsp", {rsp_err, rsp_rdata}, 0);
      rst_sys = 1'b0;
      @(negedge clk_sys);
      chk("ready_after_reset", cmd_ready, 1);

      do_cmd(1, 8'h01, 32'h80, 3, 0, rd, e, lat);
      chk("wr_latency", lat, 184);
      chk("wr_rdata", rd, 0);
      chk("wr_word", last_word, 40'h0000008001);
      chk("bridge_reg_in_w", br_mem[1], 128);

      do_cmd(0, 8'h10, 32'h0, 0, 0, rd, e, lat);
      chk("rd_status", rd, 32'h1);
      chk("rd_status_err", e, 0);
      chk("rd_latency", lat, 368);

      do_cmd(0, 8'h55, 32'h0, 2, 1, rd, e, lat);
      chk("rd_unmapped", rd, 32'hDEADBEEF);
      chk("rd_unmapped_err", e, 0);

      stuck0 = 1'b1;
      do_cmd(0, 8'h02, 32'h0, 1, 0, rd, e, lat);
      chk("stuck_rdata", rd, 0);
      chk("stuck_err", e, 1);
      stuck0 = 1'b0;

      @(negedge clk_sys);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h03;
      cmd_wdata = 32'h11;
      @(negedge clk_sys);
      cmd_valid = 1'b0;
      n = 0;
      while (!(vs_sdr && sbits >= 20) && n < 2000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("reach_bit20", sbits, 20);
      rst_sys = 1'b1;
      #1;
      chk("midrst_jtag", {tck, tdi, vs_cdr, vs_sdr, vs_udr, ir_out}, 0);
      chk("midrst_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
      @(negedge clk_sys);
      rst_sys = 1'b0;
      do_cmd(1, 8'h03, 32'hCD, 0, 0, rd, e, lat);
      chk("post_rst_latency", lat, 184);
      chk("post_rst_reg", br_mem[3], 32'hCD);
      do_cmd(0, 8'h03, 32'h0, 0, 0, rd, e, lat);
      chk("post_rst_readback", rd, 32'hCD);

      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
         case ($urandom % 4)
            0, 1, 2: a = 8'($urandom % 16);
            default: a = ($urandom % 2) ? 8'h10 : 8'($urandom);
         endcase
         do_cmd(w, a, $urandom, $urandom % 5, ($urandom % 3) == 0, rd, e, lat);
         chk("rand_latency", lat, w ? LW : 2 * LW);
      end

      @(negedge clk_sys);
      f_cmd_valid = 1'b1;
      @(negedge clk_sys);
      f_cmd_valid = 1'b0;
      t0 = cyc;
      n = 0;
      while (!f_rsp_valid && n < 1000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("fast_latency", cyc - t0, 184);
      chk("fast_rdata", f_rsp_rdata, 32'hFFFFFFFF);
      chk("fast_err", f_rsp_err, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         chk("fast_hold", {f_rsp_valid, f_cmd_ready, f_rsp_err, f_rsp_rdata}, {3'b101, 32'hFFFFFFFF});
      end
      f_rsp_ready = 1'b1;
      @(negedge clk_sys);
      f_rsp_ready = 1'b0;
      chk("fast_idle", {f_cmd_ready, f_rsp_valid, f_ir_out, f_tck}, 5'b10000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
